// File: rtl/mmu_sram_responder.sv
// MMU bus responder over a word-organised SRAM; MMU_SRAM_ALIGN_CHECK_EN makes misaligned accesses error.
// Latency: first beat one cycle after NONSEQ, then one beat per cycle, zero wait states.
// Backpressure: none; READYOUT only marks the last beat, and ERR gives a one-cycle error response.
module mmu_sram_responder #(
  parameter int          DEPTH_WORDS = 64,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        SELX,
  input  logic [31:0] ADDR,
  input  logic [31:0] WRITE_DATA,
  output logic [31:0] READ_DATA,
  input  logic        WRITE,
  input  logic [2:0]  SIZE,
  input  logic [2:0]  BURST,
  input  logic [2:0]  TRANS,
  output logic        READYOUT,
  output logic        RESP
);

  localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] WIN_BYTES = 32'(4 * DEPTH_WORDS);
  localparam logic [2:0]  TR_NONSEQ = 3'd2;
  localparam logic [2:0]  TR_SEQ    = 3'd3;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_ERR} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_addr;
  logic        r_write;
  logic [1:0]  r_size;
  logic [4:0]  r_beat;
  logic [4:0]  r_nbeats;
  logic [31:0] r_rdata;

  function automatic logic [AW-1:0] f_widx(input logic [31:0] a);
    return AW'((a - BASE_ADDR) >> 2);
  endfunction

  function automatic logic f_in_win(input logic [31:0] a);
    return (a - BASE_ADDR) < WIN_BYTES;
  endfunction

  // Low address bits below the access size are dropped before use.
  function automatic logic [31:0] f_align(input logic [31:0] a, input logic [1:0] sz);
    case (sz)
      2'd1:    return {a[31:1], 1'b0};
      2'd2:    return {a[31:2], 2'b00};
      default: return a;
    endcase
  endfunction

  function automatic logic [3:0] f_lanes(input logic [1:0] a, input logic [1:0] sz);
    case (sz)
      2'd0:    return 4'b0001 << a;
      2'd1:    return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [4:0] f_nbeats(input logic [1:0] b);
    case (b)
      2'd0:    return 5'd1;
      2'd1:    return 5'd4;
      2'd2:    return 5'd8;
      default: return 5'd16;
    endcase
  endfunction

  logic        w_last, w_accept, w_misalign, w_start_bad, w_we, w_seq;
  logic [31:0] w_start_addr, w_seq_addr, w_cur_word, w_wword, w_rd_start, w_rd_seq;
  logic [3:0]  w_lanes;

  assign w_last       = (r_beat == r_nbeats);
  assign w_accept     = SELX && (TRANS == TR_NONSEQ) &&
                        ((r_state == S_IDLE) || ((r_state == S_DATA) && w_last));
  assign w_start_addr = f_align(ADDR, SIZE[1:0]);
  assign w_seq        = (r_state == S_DATA) && !w_last && (TRANS == TR_SEQ);
  assign w_seq_addr   = r_addr + (32'd1 << r_size);
  assign w_we         = (r_state == S_DATA) && r_write;
  assign w_lanes      = f_lanes(r_addr[1:0], r_size);
  assign w_cur_word   = r_mem[f_widx(r_addr)];

`ifdef MMU_SRAM_ALIGN_CHECK_EN
  assign w_misalign = ((SIZE == 3'd1) && ADDR[0]) || ((SIZE == 3'd2) && (ADDR[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_start_bad = (SIZE > 3'd2) || (BURST > 3'd3) || !f_in_win(w_start_addr) || w_misalign;

  always_comb begin
    w_wword = w_cur_word;
    for (int i = 0; i < 4; i++) begin
      if (w_lanes[i]) w_wword[8*i +: 8] = WRITE_DATA[8*i +: 8];
    end
  end

  // Forward the beat being written so a following read of the same word sees it.
  assign w_rd_start = (w_we && (f_widx(w_start_addr) == f_widx(r_addr))) ? w_wword
                                                                        : r_mem[f_widx(w_start_addr)];
  assign w_rd_seq   = (w_we && (f_widx(w_seq_addr) == f_widx(r_addr))) ? w_wword
                                                                      : r_mem[f_widx(w_seq_addr)];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = w_start_bad ? S_ERR : S_DATA;
      end
      S_DATA: begin
        if (w_last)      w_state_nxt = w_accept ? (w_start_bad ? S_ERR : S_DATA) : S_IDLE;
        else if (w_seq)  w_state_nxt = f_in_win(w_seq_addr) ? S_DATA : S_ERR;
        else             w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      r_state  <= S_IDLE;
      r_addr   <= 32'd0;
      r_write  <= 1'b0;
      r_size   <= 2'd0;
      r_beat   <= 5'd0;
      r_nbeats <= 5'd0;
      r_rdata  <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_addr   <= w_start_addr;
        r_write  <= WRITE;
        r_size   <= SIZE[1:0];
        r_nbeats <= f_nbeats(BURST[1:0]);
        r_beat   <= 5'd1;
        if (!w_start_bad) r_rdata <= w_rd_start;
      end else if (w_seq) begin
        r_addr <= w_seq_addr;
        r_beat <= r_beat + 5'd1;
        if (f_in_win(w_seq_addr)) r_rdata <= w_rd_seq;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RSTN && w_we) r_mem[f_widx(r_addr)] <= w_wword;
  end

  assign READ_DATA = r_rdata;
  assign READYOUT  = (r_state != S_DATA) || w_last;
  assign RESP      = (r_state == S_ERR);

endmodule

// File: tb/tb_mmu_sram_responder.sv
// Directed bench for mmu_sram_responder; expectations are hand-computed constants.
module tb_mmu_sram_responder;

  logic        CLK;
  logic        RSTN;
  logic        SELX;
  logic [31:0] ADDR;
  logic [31:0] WRITE_DATA;
  logic [31:0] READ_DATA;
  logic        WRITE;
  logic [2:0]  SIZE;
  logic [2:0]  BURST;
  logic [2:0]  TRANS;
  logic        READYOUT;
  logic        RESP;

  int n_cmp = 0;
  int n_bad = 0;

  mmu_sram_responder dut (
    .CLK        (CLK),
    .RSTN       (RSTN),
    .SELX       (SELX),
    .ADDR       (ADDR),
    .WRITE_DATA (WRITE_DATA),
    .READ_DATA  (READ_DATA),
    .WRITE      (WRITE),
    .SIZE       (SIZE),
    .BURST      (BURST),
    .TRANS      (TRANS),
    .READYOUT   (READYOUT),
    .RESP       (RESP)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic w, input logic [2:0] sz, input logic [2:0] b);
    SELX  = 1'b1;
    TRANS = 3'd2;
    ADDR  = a;
    WRITE = w;
    SIZE  = sz;
    BURST = b;
  endtask

  task automatic go_idle;
    SELX  = 1'b0;
    TRANS = 3'd0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
    issue(a, 1'b1, sz, 3'd0);
    tick;
    go_idle;
    WRITE_DATA = d;
    tick;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    issue(a, 1'b0, 3'd2, 3'd0);
    tick;
    chk({tag, "_data"}, READ_DATA, exp);
    chk({tag, "_rdy"}, {31'd0, READYOUT}, 32'd1);
    go_idle;
    tick;
  endtask

  initial begin
    RSTN = 1'b0; SELX = 1'b0; ADDR = 32'd0; WRITE_DATA = 32'd0;
    WRITE = 1'b0; SIZE = 3'd0; BURST = 3'd0; TRANS = 3'd0;

    tick;
    tick;
    chk("rst_ready", {31'd0, READYOUT}, 32'd1);
    chk("rst_resp",  {31'd0, RESP}, 32'd0);
    chk("rst_rdata", READ_DATA, 32'd0);
    RSTN = 1'b1;
    tick;
    chk("idle_ready", {31'd0, READYOUT}, 32'd1);

    wr(32'h10, 3'd2, 32'hDEADBEEF);
    rd_chk("word_rd", 32'h10, 32'hDEADBEEF);

    // INCR4 write of 1..4 at 0x20 whose last beat hands over directly to an INCR4 read.
    issue(32'h20, 1'b1, 3'd2, 3'd1);
    tick;
    for (int i = 1; i <= 4; i++) begin
      WRITE_DATA = i;
      chk("incr4_wr_rdy", {31'd0, READYOUT}, (i == 4) ? 32'd1 : 32'd0);
      if (i < 4) TRANS = 3'd3;
      else issue(32'h20, 1'b0, 3'd2, 3'd1);
      tick;
    end
    for (int i = 1; i <= 4; i++) begin
      chk("incr4_rd_data", READ_DATA, i);
      chk("incr4_rd_rdy", {31'd0, READYOUT}, (i == 4) ? 32'd1 : 32'd0);
      chk("incr4_rd_resp", {31'd0, RESP}, 32'd0);
      if (i < 4) begin
        SELX = 1'b0;
        TRANS = 3'd3;
      end else go_idle;
      tick;
    end

    wr(32'h30, 3'd2, 32'h11223344);
    wr(32'h33, 3'd0, 32'hAB000000);
    rd_chk("byte_wr", 32'h30, 32'hAB223344);
    wr(32'h12, 3'd1, 32'h5A5A0000);
    rd_chk("half_wr", 32'h10, 32'h5A5ABEEF);

    wr(32'h00, 3'd2, 32'h0BADF00D);
    rd_chk("w0_rd", 32'h00, 32'h0BADF00D);

    issue(32'h100, 1'b1, 3'd2, 3'd0);
    WRITE_DATA = 32'h12345678;
    tick;
    chk("oow_resp",  {31'd0, RESP}, 32'd1);
    chk("oow_rdy",   {31'd0, READYOUT}, 32'd1);
    chk("oow_rdata", READ_DATA, 32'h0BADF00D);
    go_idle;
    tick;
    chk("oow_after_resp", {31'd0, RESP}, 32'd0);
    chk("oow_after_rdy",  {31'd0, READYOUT}, 32'd1);

    issue(32'h10, 1'b1, 3'd2, 3'd5);
    tick;
    chk("burst5_resp", {31'd0, RESP}, 32'd1);
    go_idle;
    tick;
    issue(32'h10, 1'b1, 3'd3, 3'd0);
    tick;
    chk("size3_resp", {31'd0, RESP}, 32'd1);
    go_idle;
    tick;
    rd_chk("illegal_nochg", 32'h10, 32'h5A5ABEEF);

    // INCR4 from 0xF8: third beat crosses the window end.
    issue(32'hF8, 1'b1, 3'd2, 3'd1);
    tick;
    chk("edge_b1_rdy",  {31'd0, READYOUT}, 32'd0);
    chk("edge_b1_resp", {31'd0, RESP}, 32'd0);
    SELX = 1'b0; TRANS = 3'd3; WRITE_DATA = 32'hA1A1A1A1;
    tick;
    chk("edge_b2_rdy",  {31'd0, READYOUT}, 32'd0);
    chk("edge_b2_resp", {31'd0, RESP}, 32'd0);
    WRITE_DATA = 32'hA2A2A2A2;
    tick;
    chk("edge_err_resp", {31'd0, RESP}, 32'd1);
    chk("edge_err_rdy",  {31'd0, READYOUT}, 32'd1);
    WRITE_DATA = 32'hEEEEEEEE;
    go_idle;
    tick;
    chk("edge_idle_resp", {31'd0, RESP}, 32'd0);
    rd_chk("edge_f8", 32'hF8, 32'hA1A1A1A1);
    rd_chk("edge_fc", 32'hFC, 32'hA2A2A2A2);
    rd_chk("edge_w0", 32'h00, 32'h0BADF00D);

    wr(32'h48, 3'd2, 32'h99999999);
    issue(32'h40, 1'b1, 3'd2, 3'd2);
    tick;
    SELX = 1'b0; TRANS = 3'd3; WRITE_DATA = 32'hB1B1B1B1;
    tick;
    chk("abort_b2_rdy", {31'd0, READYOUT}, 32'd0);
    go_idle;
    WRITE_DATA = 32'hB2B2B2B2;
    tick;
    chk("abort_rdy",  {31'd0, READYOUT}, 32'd1);
    chk("abort_resp", {31'd0, RESP}, 32'd0);
    rd_chk("abort_40", 32'h40, 32'hB1B1B1B1);
    rd_chk("abort_44", 32'h44, 32'hB2B2B2B2);
    rd_chk("abort_48", 32'h48, 32'h99999999);

    issue(32'h02, 1'b1, 3'd2, 3'd0);
    WRITE_DATA = 32'h77665544;
    tick;
`ifdef MMU_SRAM_ALIGN_CHECK_EN
    chk("align_resp", {31'd0, RESP}, 32'd1);
    go_idle;
    tick;
    rd_chk("align_w0", 32'h00, 32'h0BADF00D);
`else
    chk("align_resp", {31'd0, RESP}, 32'd0);
    chk("align_rdy",  {31'd0, READYOUT}, 32'd1);
    go_idle;
    tick;
    rd_chk("align_w0", 32'h00, 32'h77665544);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
